// File: rtl/core_pkg.sv
// Shared types for the TOY execute-side issue sequencer: opcodes, FSM states
// and the TOY-to-ALU opcode mapping.
package core_pkg;

    typedef enum logic [3:0] {
        TOY_HLT = 4'h0, TOY_ADD = 4'h1, TOY_SUB = 4'h2, TOY_AND = 4'h3,
        TOY_XOR = 4'h4, TOY_SHL = 4'h5, TOY_SHR = 4'h6, TOY_LDA = 4'h7,
        TOY_LD  = 4'h8, TOY_ST  = 4'h9, TOY_LDI = 4'hA, TOY_STI = 4'hB,
        TOY_BZ  = 4'hC, TOY_BP  = 4'hD, TOY_JR  = 4'hE, TOY_JL  = 4'hF
    } toy_op_e;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0, ALU_SUB = 3'd1, ALU_AND  = 3'd2, ALU_XOR = 3'd3,
        ALU_SHL    = 3'd4, ALU_SHR = 3'd5, ALU_RSVD = 3'd6, ALU_PASS_B = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_CAPTURE = 2'd3
    } issue_state_e;

    // Only opcodes 1..7 are executed by the ALU; the rest belong to other units.
    function automatic logic is_alu_op(input toy_op_e op);
        return (op != TOY_HLT) && (op <= TOY_LDA);
    endfunction

    function automatic alu_op_e map_op(input toy_op_e op);
        case (op)
            TOY_ADD: return ALU_ADD;
            TOY_SUB: return ALU_SUB;
            TOY_AND: return ALU_AND;
            TOY_XOR: return ALU_XOR;
            TOY_SHL: return ALU_SHL;
            TOY_SHR: return ALU_SHR;
            TOY_LDA: return ALU_PASS_B;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/core_regfile.sv
// NREGS x WIDTH register file: two registered read ports, one write port,
// R0 hardwired to zero, write-first bypass on a same-cycle read/write hit.
module core_regfile import core_pkg::*; #(
    parameter  int NREGS = 16,
    parameter  int WIDTH = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [AW-1:0]    ra_addr_i,
    output logic [WIDTH-1:0] ra_data_o,
    input  logic [AW-1:0]    rb_addr_i,
    output logic [WIDTH-1:0] rb_data_o,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i
);

    logic [WIDTH-1:0] mem [NREGS];
    logic [WIDTH-1:0] ra_next, rb_next;

    always_comb begin
        ra_next = mem[ra_addr_i];
        rb_next = mem[rb_addr_i];
        if (we_i && waddr_i == ra_addr_i) ra_next = wdata_i;
        if (we_i && waddr_i == rb_addr_i) rb_next = wdata_i;
        if (ra_addr_i == '0) ra_next = '0;
        if (rb_addr_i == '0) rb_next = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the array is reset because software-visible registers must read 0 after reset;
            // this rules out a RAM macro, acceptable for 16 entries.
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
            ra_data_o <= '0;
            rb_data_o <= '0;
        end else begin
            if (we_i && waddr_i != '0) mem[waddr_i] <= wdata_i;
            ra_data_o <= ra_next;
            rb_data_o <= rb_next;
        end
    end

endmodule

// File: rtl/core_issue.sv
// Execute-side issue sequencer: IDLE -> READ -> ISSUE -> CAPTURE for the registered ALU.
// Optional macro CORE_ISSUE_PERF_EN adds the retired_o writeback counter.
module core_issue import core_pkg::*; #(
    parameter  int NREGS = 16,
    parameter  int WIDTH = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             instr_valid_i,
    input  logic [15:0]      instr_i,
    output logic             instr_ready_o,
    output logic [2:0]       alu_op_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    input  logic [WIDTH-1:0] alu_c_i,
    input  logic             ext_wr_valid_i,
    input  logic [AW-1:0]    ext_wr_addr_i,
    input  logic [WIDTH-1:0] ext_wr_data_i,
    output logic             ext_wr_ready_o,
    output logic             wb_valid_o,
    output logic [AW-1:0]    wb_addr_o,
    output logic [WIDTH-1:0] wb_data_o,
    output logic             unsupp_o
`ifdef CORE_ISSUE_PERF_EN
    ,
    output logic [31:0]      retired_o
`endif
);

    issue_state_e     state_q;
    logic [15:0]      instr_q;
    toy_op_e          op_in, op_q;
    logic [2:0]       alu_op_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    alu_op_e          issue_op;
    logic [WIDTH-1:0] issue_a, issue_b;
    logic [WIDTH-1:0] rf_ra_data, rf_rb_data;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [WIDTH-1:0] rf_wdata;
    logic             in_capture;

    assign op_in      = toy_op_e'(instr_i[15:12]);
    assign op_q       = toy_op_e'(instr_q[15:12]);
    assign in_capture = (state_q == ST_CAPTURE);

    assign instr_ready_o  = (state_q == ST_IDLE);
    assign ext_wr_ready_o = ~rst_i & ~in_capture;

    // ALU writeback owns the write port in CAPTURE; the side port waits a cycle.
    assign rf_we    = in_capture | (ext_wr_valid_i & ext_wr_ready_o);
    assign rf_waddr = in_capture ? instr_q[8 +: AW] : ext_wr_addr_i;
    assign rf_wdata = in_capture ? alu_c_i : ext_wr_data_i;

    core_regfile #(.NREGS(NREGS), .WIDTH(WIDTH)) u_regfile (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ra_addr_i (instr_q[4 +: AW]),
        .ra_data_o (rf_ra_data),
        .rb_addr_i (instr_q[0 +: AW]),
        .rb_data_o (rf_rb_data),
        .we_i      (rf_we),
        .waddr_i   (rf_waddr),
        .wdata_i   (rf_wdata)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        issue_op = map_op(op_q);
        issue_a  = rf_ra_data;
        issue_b  = rf_rb_data;
        if (op_q == TOY_LDA) begin
            issue_a = '0;
            issue_b = WIDTH'(instr_q[7:0]);
        end
    end

    // Operands go straight from the read registers during ISSUE and are held afterwards.
    assign alu_op_o = (state_q == ST_ISSUE) ? issue_op : alu_op_q;
    assign alu_a_o  = (state_q == ST_ISSUE) ? issue_a  : alu_a_q;
    assign alu_b_o  = (state_q == ST_ISSUE) ? issue_b  : alu_b_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            wb_valid_o <= 1'b0;
            wb_addr_o  <= '0;
            wb_data_o  <= '0;
            unsupp_o   <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            unsupp_o   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid_i) begin
                        instr_q <= instr_i;
                        if (is_alu_op(op_in)) state_q <= ST_READ;
                        else                  unsupp_o <= 1'b1;
                    end
                end
                ST_READ: state_q <= ST_ISSUE;
                ST_ISSUE: begin
                    alu_op_q <= issue_op;
                    alu_a_q  <= issue_a;
                    alu_b_q  <= issue_b;
                    state_q  <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    wb_valid_o <= 1'b1;
                    wb_addr_o  <= instr_q[8 +: AW];
                    wb_data_o  <= alu_c_i;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef CORE_ISSUE_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)           retired_o <= '0;
        else if (wb_valid_o) retired_o <= retired_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_core_issue.sv
// Directed self-checking bench for core_issue with a behavioural registered ALU.
module tb_core_issue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_valid_i;
    logic [15:0] instr_i;
    logic        instr_ready_o;
    logic [2:0]  alu_op_o;
    logic [15:0] alu_a_o, alu_b_o;
    logic [15:0] alu_c_i;
    logic        ext_wr_valid_i;
    logic [3:0]  ext_wr_addr_i;
    logic [15:0] ext_wr_data_i;
    logic        ext_wr_ready_o;
    logic        wb_valid_o;
    logic [3:0]  wb_addr_o;
    logic [15:0] wb_data_o;
    logic        unsupp_o;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    core_issue dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .instr_valid_i  (instr_valid_i),
        .instr_i        (instr_i),
        .instr_ready_o  (instr_ready_o),
        .alu_op_o       (alu_op_o),
        .alu_a_o        (alu_a_o),
        .alu_b_o        (alu_b_o),
        .alu_c_i        (alu_c_i),
        .ext_wr_valid_i (ext_wr_valid_i),
        .ext_wr_addr_i  (ext_wr_addr_i),
        .ext_wr_data_i  (ext_wr_data_i),
        .ext_wr_ready_o (ext_wr_ready_o),
        .wb_valid_o     (wb_valid_o),
        .wb_addr_o      (wb_addr_o),
        .wb_data_o      (wb_data_o),
        .unsupp_o       (unsupp_o)
    );

    // Registered TOY ALU: result appears the cycle after operands are presented.
    always @(posedge clk_i) begin
        case (alu_op_o)
            3'd0: alu_c_i <= alu_a_o + alu_b_o;
            3'd1: alu_c_i <= alu_a_o - alu_b_o;
            3'd2: alu_c_i <= alu_a_o & alu_b_o;
            3'd3: alu_c_i <= alu_a_o ^ alu_b_o;
            3'd4: alu_c_i <= (alu_b_o >= 16'd16) ? 16'h0000 : (alu_a_o << alu_b_o[3:0]);
            3'd5: alu_c_i <= (alu_b_o >= 16'd16) ? 16'h0000 : (alu_a_o >> alu_b_o[3:0]);
            3'd7: alu_c_i <= alu_b_o;
            default: alu_c_i <= 16'h0000;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic ext_write(input logic [3:0] addr, input logic [15:0] data);
        ext_wr_valid_i = 1'b1;
        ext_wr_addr_i  = addr;
        ext_wr_data_i  = data;
        step;
        ext_wr_valid_i = 1'b0;
    endtask

    // ext_phase: 0 none, 1 side write during READ, 2 side write offered during CAPTURE.
    task automatic run_alu(input logic [15:0] instr, input logic [2:0] exp_op,
                           input logic [15:0] exp_a, input logic [15:0] exp_b,
                           input logic [15:0] exp_wb, input int ext_phase,
                           input logic [3:0] x_addr, input logic [15:0] x_data);
        check("ready_idle", instr_ready_o, 1);
        instr_valid_i = 1'b1;
        instr_i       = instr;
        step;
        instr_valid_i = 1'b0;
        check("ready_busy", instr_ready_o, 0);
        if (ext_phase == 1) begin
            ext_wr_valid_i = 1'b1;
            ext_wr_addr_i  = x_addr;
            ext_wr_data_i  = x_data;
        end
        step;
        ext_wr_valid_i = 1'b0;
        check("issue_op", alu_op_o, exp_op);
        check("issue_a", alu_a_o, exp_a);
        check("issue_b", alu_b_o, exp_b);
        step;
        check("capture_ext_ready", ext_wr_ready_o, 0);
        check("wb_early", wb_valid_o, 0);
        if (ext_phase == 2) begin
            ext_wr_valid_i = 1'b1;
            ext_wr_addr_i  = x_addr;
            ext_wr_data_i  = x_data;
        end
        step;
        check("wb_valid", wb_valid_o, 1);
        check("wb_addr", wb_addr_o, instr[11:8]);
        check("wb_data", wb_data_o, exp_wb);
        if (ext_phase == 2) begin
            check("ext_ready_after_capture", ext_wr_ready_o, 1);
            step;
            ext_wr_valid_i = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_i          = 1'b1;
        instr_valid_i  = 1'b0;
        instr_i        = 16'h0000;
        ext_wr_valid_i = 1'b0;
        ext_wr_addr_i  = 4'h0;
        ext_wr_data_i  = 16'h0000;
        step;
        step;
        check("rst_ext_ready", ext_wr_ready_o, 0);
        check("rst_instr_ready", instr_ready_o, 1);
        check("rst_alu_op", alu_op_o, 0);
        check("rst_alu_a", alu_a_o, 0);
        check("rst_alu_b", alu_b_o, 0);
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_wb_addr", wb_addr_o, 0);
        check("rst_wb_data", wb_data_o, 0);
        check("rst_unsupp", unsupp_o, 0);
        rst_i = 1'b0;
        step;
        check("ext_ready_idle", ext_wr_ready_o, 1);

        ext_write(4'h1, 16'h0005);
        ext_write(4'h2, 16'h0003);
        run_alu(16'h1312, 3'd0, 16'h0005, 16'h0003, 16'h0008, 0, 4'h0, 16'h0000);
        run_alu(16'h7A42, 3'd7, 16'h0000, 16'h0042, 16'h0042, 0, 4'h0, 16'h0000);
        run_alu(16'h5BA2, 3'd4, 16'h0042, 16'h0003, 16'h0210, 0, 4'h0, 16'h0000);
        check("alu_a_hold", alu_a_o, 16'h0042);
        check("alu_op_hold", alu_op_o, 3'd4);
        ext_write(4'h1, 16'h0010);
        run_alu(16'h5BA1, 3'd4, 16'h0042, 16'h0010, 16'h0000, 0, 4'h0, 16'h0000);

        // Write to R0 still pulses wb, and R0 reads back 0
        run_alu(16'h1012, 3'd0, 16'h0010, 16'h0003, 16'h0013, 0, 4'h0, 16'h0000);
        run_alu(16'h1300, 3'd0, 16'h0000, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000);

        // Side write stalled by CAPTURE, then R4 read back through shr by 0
        run_alu(16'h1512, 3'd0, 16'h0010, 16'h0003, 16'h0013, 2, 4'h4, 16'hBEEF);
        run_alu(16'h6640, 3'd5, 16'hBEEF, 16'h0000, 16'hBEEF, 0, 4'h0, 16'h0000);

        // Side write in the READ cycle is seen by the same read (write-first)
        run_alu(16'h1711, 3'd0, 16'h0100, 16'h0100, 16'h0200, 1, 4'h1, 16'h0100);
        run_alu(16'h2312, 3'd1, 16'h0100, 16'h0003, 16'h00FD, 0, 4'h0, 16'h0000);
        run_alu(16'h4812, 3'd3, 16'h0100, 16'h0003, 16'h0103, 0, 4'h0, 16'h0000);
        run_alu(16'h3912, 3'd2, 16'h0100, 16'h0003, 16'h0000, 0, 4'h0, 16'h0000);

        // Non-ALU opcode
        instr_valid_i = 1'b1;
        instr_i       = 16'h8123;
        step;
        instr_valid_i = 1'b0;
        check("unsupp_pulse", unsupp_o, 1);
        check("unsupp_no_wb", wb_valid_o, 0);
        check("unsupp_ready", instr_ready_o, 1);
        step;
        check("unsupp_clear", unsupp_o, 0);
        check("unsupp_no_wb_late", wb_valid_o, 0);

        // Reset in ISSUE discards the instruction and clears the register file
        instr_valid_i = 1'b1;
        instr_i       = 16'h1312;
        step;
        instr_valid_i = 1'b0;
        step;
        check("pre_rst_issue_a", alu_a_o, 16'h0100);
        rst_i = 1'b1;
        step;
        rst_i = 1'b0;
        check("rst_issue_wb", wb_valid_o, 0);
        check("rst_issue_ready", instr_ready_o, 1);
        check("rst_issue_op", alu_op_o, 0);
        check("rst_issue_a", alu_a_o, 0);
        check("rst_issue_b", alu_b_o, 0);
        step;
        check("rst_issue_wb_late", wb_valid_o, 0);
        step;
        check("rst_issue_wb_late2", wb_valid_o, 0);
        run_alu(16'h1312, 3'd0, 16'h0000, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
